// File: rtl/layer_compositor_pkg.sv
// Shared types and constants for the layer compositor: fade states, colour type,
// default transparent key and full-brightness level.
package compositor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    BLACK    = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_t;

  typedef logic [23:0] rgb_t;

  localparam rgb_t       KEY_DEFAULT = 24'hF442EE;
  localparam logic [4:0] LEVEL_MAX   = 5'd16;

endpackage

// File: rtl/layer_compositor_if.sv
// Pixel/layer bus between the video timing/palette side and the compositor.
interface layer_compositor_if
  import compositor_pkg::*;
#(
  parameter int NUM_LAYERS = 8
);
  logic                       pix_valid;
  logic                       frame_start;
  logic [NUM_LAYERS-1:0]      layer_hit;
  logic [NUM_LAYERS*24-1:0]   layer_color;
  rgb_t                       bg_color;
  logic                       fade_req;
  logic [7:0]                 VGA_R;
  logic [7:0]                 VGA_G;
  logic [7:0]                 VGA_B;
  logic                       fade_busy;
  logic                       fade_black;

  modport master (
    output pix_valid, frame_start, layer_hit, layer_color, bg_color, fade_req,
    input  VGA_R, VGA_G, VGA_B, fade_busy, fade_black
  );

  modport slave (
    input  pix_valid, frame_start, layer_hit, layer_color, bg_color, fade_req,
    output VGA_R, VGA_G, VGA_B, fade_busy, fade_black
  );
endinterface

// File: rtl/layer_compositor_color_scaler.sv
// One colour channel brightness scaler: (c * level) >> 4 with level 0..16.
module color_scaler (
  input  logic [7:0] i_c,
  input  logic [4:0] i_level,
  output logic [7:0] o_c
);
  logic [12:0] w_prod;

  assign w_prod = 13'(i_c) * 13'(i_level);
  assign o_c    = 8'(w_prod >> 4);
endmodule

// File: rtl/layer_compositor.sv
// Priority sprite-layer compositor with colour-key transparency and an optional
// frame-synchronous fade-out/fade-in, enabled by defining COMPOSITOR_FADE_EN.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int   NUM_LAYERS  = 8,
  parameter int   LAT         = 2,
  parameter rgb_t KEY         = KEY_DEFAULT,
  parameter int   STEP        = 2,
  parameter int   HOLD_FRAMES = 4
)(
  input  logic         Clk,
  input  logic         Reset,
  layer_compositor_if.slave bus
);

  logic                  r_valid_pipe [LAT];
  logic [NUM_LAYERS-1:0] r_hit_pipe   [LAT];
  logic                  w_valid_d;
  logic [NUM_LAYERS-1:0] w_hit_d;
  rgb_t                  w_sel;
  rgb_t                  w_scaled;
  rgb_t                  r_pix;

  // Hit/valid pipeline lines them up with the palette outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < LAT; i++) begin
        r_valid_pipe[i] <= 1'b0;
        r_hit_pipe[i]   <= '0;
      end
    end else begin
      r_valid_pipe[0] <= bus.pix_valid;
      r_hit_pipe[0]   <= bus.layer_hit;
      for (int i = 1; i < LAT; i++) begin
        r_valid_pipe[i] <= r_valid_pipe[i-1];
        r_hit_pipe[i]   <= r_hit_pipe[i-1];
      end
    end
  end

  assign w_valid_d = r_valid_pipe[LAT-1];
  assign w_hit_d   = r_hit_pipe[LAT-1];

  // Walk from lowest priority upward so layer 0 overrides everything else
  always_comb begin
    w_sel = bus.bg_color;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      w_sel = (w_hit_d[i] && (bus.layer_color[24*i +: 24] != KEY))
              ? bus.layer_color[24*i +: 24] : w_sel;
    end
  end

`ifdef COMPOSITOR_FADE_EN
  localparam logic [4:0] STEP_L    = 5'(STEP);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

  fade_state_t r_state, w_state_nxt;
  logic [4:0]  r_level, w_level_nxt, w_level_dec;
  logic [5:0]  w_level_inc;
  logic [7:0]  r_hold, w_hold_nxt;
  logic        r_fade_busy, r_fade_black, w_black_pulse;

  assign w_level_dec = (r_level > STEP_L) ? (r_level - STEP_L) : 5'd0;
  assign w_level_inc = ({1'b0, r_level} + {1'b0, STEP_L} > {1'b0, LEVEL_MAX})
                       ? {1'b0, LEVEL_MAX} : ({1'b0, r_level} + {1'b0, STEP_L});

  // Level moves only on frame_start so brightness never changes mid-frame
  always_comb begin
    w_state_nxt   = r_state;
    w_level_nxt   = r_level;
    w_hold_nxt    = r_hold;
    w_black_pulse = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.fade_req) w_state_nxt = FADE_OUT;
        else              w_state_nxt = IDLE;
      end
      FADE_OUT: begin
        if (bus.frame_start) begin
          w_level_nxt = w_level_dec;
          if (w_level_dec == 5'd0) begin
            w_state_nxt   = BLACK;
            w_black_pulse = 1'b1;
            w_hold_nxt    = 8'd0;
          end else begin
            w_state_nxt = FADE_OUT;
          end
        end else begin
          w_state_nxt = FADE_OUT;
        end
      end
      BLACK: begin
        if (bus.frame_start) begin
          if (r_hold == HOLD_LAST) begin
            w_state_nxt = FADE_IN;
            w_hold_nxt  = 8'd0;
          end else begin
            w_hold_nxt  = r_hold + 8'd1;
          end
        end else begin
          w_hold_nxt = r_hold;
        end
      end
      FADE_IN: begin
        if (bus.frame_start) begin
          w_level_nxt = w_level_inc[4:0];
          if (w_level_inc == {1'b0, LEVEL_MAX}) w_state_nxt = IDLE;
          else                                  w_state_nxt = FADE_IN;
        end else begin
          w_state_nxt = FADE_IN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_level_nxt = LEVEL_MAX;
        w_hold_nxt  = 8'd0;
      end
    endcase
  end

  // Fade state, level and status flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_level      <= LEVEL_MAX;
      r_hold       <= 8'd0;
      r_fade_busy  <= 1'b0;
      r_fade_black <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_level      <= w_level_nxt;
      r_hold       <= w_hold_nxt;
      r_fade_busy  <= (w_state_nxt != IDLE);
      r_fade_black <= w_black_pulse;
    end
  end

  color_scaler u_scale_r (.i_c(w_sel[23:16]), .i_level(r_level), .o_c(w_scaled[23:16]));
  color_scaler u_scale_g (.i_c(w_sel[15:8]),  .i_level(r_level), .o_c(w_scaled[15:8]));
  color_scaler u_scale_b (.i_c(w_sel[7:0]),   .i_level(r_level), .o_c(w_scaled[7:0]));

  assign bus.fade_busy  = r_fade_busy;
  assign bus.fade_black = r_fade_black;
`else
  logic w_unused_bits;

  assign w_unused_bits  = ^{bus.fade_req, bus.frame_start, 8'(STEP), 8'(HOLD_FRAMES)};
  assign w_scaled       = w_sel;
  assign bus.fade_busy  = 1'b0;
  assign bus.fade_black = 1'b0;
`endif

  // Output register; blanking forces black outside the visible area
  always_ff @(posedge Clk) begin
    if (Reset)           r_pix <= 24'h000000;
    else if (!w_valid_d) r_pix <= 24'h000000;
    else                 r_pix <= w_scaled;
  end

  assign bus.VGA_R = r_pix[23:16];
  assign bus.VGA_G = r_pix[15:8];
  assign bus.VGA_B = r_pix[7:0];

endmodule
